ps2_dir_decoder: RTL
====================

Name: ps2_dir_decoder

Overview:
- Sits between PS2_Interface and the game/VGA logic.
- Consumes the raw PS/2 scancode byte stream (ps2_key_data plus ps2_key_pressed strobe) and parses make, break and extended (E0) sequences.
- Produces a latched Pac-Man direction, a per-direction held mask and a pause toggle, so the game never sees raw scancodes.

Parameters:
TIMEOUT_CYCLES, 500000, cycles allowed between a prefix byte (E0/F0) and the next byte before the parser aborts (10 ms at 50 MHz)
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clock  input  1  system clock; every register on rising edge
resetn  input  1  asynchronous, active-low reset
key_strobe  input  1  one-cycle pulse, new byte valid on key_data
key_data  input  8  scancode byte, sampled only when key_strobe=1
dir  output  2  latched direction: 00 up, 01 down, 10 left, 11 right
dir_change  output  1  one-cycle pulse when dir is (re)loaded by a fresh press
held  output  4  bit0 up, bit1 down, bit2 left, bit3 right; 1 while key is down
paused  output  1  pause state, toggled by P
timeout  output  1  one-cycle pulse when a prefix sequence is aborted

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-low, resetn.
- Reset values: dir=2'b10 (left), dir_change=0, held=4'b0, paused=0, timeout=0, internal p_held=0, state=IDLE, counter=0.
- All outputs are registered. Updates land on the clock edge that samples key_strobe with the final byte of a sequence (latency 1 cycle).
- Key map, make codes:
  - Up: E0 75 or 1D (W)
  - Down: E0 72 or 1B (S)
  - Left: E0 6B or 1C (A)
  - Right: E0 74 or 23 (D)
  - Pause: 4D (P)
  - Non-extended 75/72/6B/74 (keypad) are ignored.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0_F0.
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; other byte -> decode as plain make, stay IDLE.
  - GOT_E0: F0 -> GOT_E0_F0; E0 -> stay, counter cleared; other byte -> decode as extended make, -> IDLE.
  - GOT_F0: F0 -> stay, counter cleared; other byte -> decode as plain break, -> IDLE.
  - GOT_E0_F0: any byte except E0/F0 -> decode as extended break, -> IDLE; E0/F0 -> IDLE, no action.
  - Unmapped codes (including E1) are silently ignored and return to IDLE.
- Make of a direction:
  - held bit already 1 (typematic repeat): no change, dir_change=0.
  - held bit 0: set held bit. If paused=0, also dir<=code and dir_change=1, even if the code equals the current dir.
  - If paused=1: dir frozen, dir_change=0.
- Break of a direction: clear its held bit only; dir is unchanged. Break of a key not held is a no-op. Arrow and WASD for the same direction share one held bit; either break clears it.
- Pause:
  - Make of P with p_held=0: paused<=~paused, p_held<=1. Make with p_held=1 (repeat) is ignored.
  - Break of P: p_held<=0.
- Timeout: counter increments every cycle while state!=IDLE and key_strobe=0, and clears on any strobe or in IDLE.
  - When counter reaches TIMEOUT_CYCLES-1: state<=IDLE, timeout=1 for one cycle, counter<=0.
  - If key_strobe coincides with expiry, the strobe wins: the byte is processed normally and timeout=0.
- dir_change and timeout are never held longer than one cycle.
- Asserting resetn mid-sequence returns everything to reset values immediately, with no pulses emitted.

Test Plan:
- Reset then idle 100 cycles -> dir=10, held=0000, paused=0, no pulses.
- Bytes E0,75 -> one cycle after the 75 strobe: dir=00, held=0001, dir_change pulse of 1 cycle. Repeat E0,75 x3 -> no further dir_change. E0,F0,75 -> held=0000, dir stays 00.
- 1D (W) make, then E0,74 make -> dir=11, held=1001, two dir_change pulses. F0,1D -> held=1000.
- 4D, 4D (repeat), F0,4D, 4D -> paused goes 0->1->1->1->0. While paused=1, E0,6B -> held bit2 set, dir unchanged, no dir_change.
- With TIMEOUT_CYCLES=16: send E0 then nothing -> timeout pulse exactly 16 cycles after the strobe, state IDLE. Next byte 75 alone -> ignored, dir unchanged.
- Send E0, then 6B exactly on the expiry cycle -> no timeout pulse, dir=10 with a dir_change pulse. Assert resetn low during GOT_E0_F0 -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_dir_decoder.sv
// PS/2 scancode parser for the Pac-Man game: turns make/break/E0 byte sequences
// into a latched direction, a per-direction held mask and a pause toggle.
module ps2_dir_decoder #(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int CNT_W          = 20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_strobe,
    input  logic [7:0] key_data,
    output logic [1:0] dir,
    output logic       dir_change,
    output logic [3:0] held,
    output logic       paused,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    // Handshake: key_strobe is a one-cycle valid with no back-pressure; key_data
    // is only looked at while key_strobe=1 and every strobed byte is consumed.

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GOT_E0    = 2'd1,
        S_GOT_F0    = 2'd2,
        S_GOT_E0_F0 = 2'd3
    } state_t;

    localparam logic [7:0]       CODE_E0 = 8'hE0;
    localparam logic [7:0]       CODE_F0 = 8'hF0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dir;
    logic             r_dir_change;
    logic [3:0]       r_held;
    logic             r_paused;
    logic             r_p_held;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_dir_nxt;
    logic             w_dir_change_nxt;
    logic [3:0]       w_held_nxt;
    logic             w_paused_nxt;
    logic             w_p_held_nxt;
    logic             w_timeout_nxt;

    logic             w_dec_valid;
    logic             w_dec_ext;
    logic             w_dec_brk;
    logic [3:0]       w_lk;

    // Returns {is_dir, is_pause, dir[1:0]}; anything not listed is ignored.
    function automatic logic [3:0] f_lookup(input logic ext, input logic [7:0] code);
        logic [3:0] res;
        res = 4'b0000;
        case ({ext, code})
            {1'b1, 8'h75}, {1'b0, 8'h1D}: res = 4'b1000;
            {1'b1, 8'h72}, {1'b0, 8'h1B}: res = 4'b1001;
            {1'b1, 8'h6B}, {1'b0, 8'h1C}: res = 4'b1010;
            {1'b1, 8'h74}, {1'b0, 8'h23}: res = 4'b1011;
            {1'b0, 8'h4D}:                res = 4'b0100;
            default:                      res = 4'b0000;
        endcase
        return res;
    endfunction

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_timeout_nxt    = 1'b0;
        w_dec_valid      = 1'b0;
        w_dec_ext        = 1'b0;
        w_dec_brk        = 1'b0;

        if (key_strobe) begin
            w_cnt_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (key_data == CODE_E0) begin
                        w_state_nxt = S_GOT_E0;
                    end else if (key_data == CODE_F0) begin
                        w_state_nxt = S_GOT_F0;
                    end else begin
                        w_dec_valid = 1'b1;
                    end
                end
                S_GOT_E0: begin
                    if (key_data == CODE_F0) begin
                        w_state_nxt = S_GOT_E0_F0;
                    end else if (key_data != CODE_E0) begin
                        w_dec_valid = 1'b1;
                        w_dec_ext   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_GOT_F0: begin
                    if (key_data != CODE_F0) begin
                        w_dec_valid = 1'b1;
                        w_dec_brk   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_dec_valid = (key_data != CODE_E0) && (key_data != CODE_F0);
                    w_dec_ext   = 1'b1;
                    w_dec_brk   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (r_state != S_IDLE) begin
            // A stalled prefix must not swallow the next unrelated keystroke.
            if (r_cnt == CNT_MAX) begin
                w_state_nxt   = S_IDLE;
                w_cnt_nxt     = '0;
                w_timeout_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_nxt = '0;
        end
    end

    always_comb begin
        w_dir_nxt        = r_dir;
        w_dir_change_nxt = 1'b0;
        w_held_nxt       = r_held;
        w_paused_nxt     = r_paused;
        w_p_held_nxt     = r_p_held;
        w_lk             = f_lookup(w_dec_ext, key_data);

        if (w_dec_valid && w_lk[3]) begin
            if (w_dec_brk) begin
                w_held_nxt[w_lk[1:0]] = 1'b0;
            end else if (!r_held[w_lk[1:0]]) begin
                w_held_nxt[w_lk[1:0]] = 1'b1;
                if (!r_paused) begin
                    w_dir_nxt        = w_lk[1:0];
                    w_dir_change_nxt = 1'b1;
                end
            end
        end else if (w_dec_valid && w_lk[2]) begin
            if (w_dec_brk) begin
                w_p_held_nxt = 1'b0;
            end else if (!r_p_held) begin
                w_paused_nxt = ~r_paused;
                w_p_held_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dir        <= 2'b10;
            r_dir_change <= 1'b0;
            r_held       <= 4'b0000;
            r_paused     <= 1'b0;
            r_p_held     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dir        <= w_dir_nxt;
            r_dir_change <= w_dir_change_nxt;
            r_held       <= w_held_nxt;
            r_paused     <= w_paused_nxt;
            r_p_held     <= w_p_held_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign dir        = r_dir;
    assign dir_change = r_dir_change;
    assign held       = r_held;
    assign paused     = r_paused;
    assign timeout    = r_timeout;
    assign dbg_state  = r_state;

endmodule
